// File: rtl/skullfet_tester_pkg.sv
// Shared types and constants for the SkullFET inverter tester.
package skullfet_tester_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StDone
    } state_e;

    localparam logic [3:0] RESULT_IDLE  = 4'h0;
    localparam logic [3:0] RESULT_PASS  = 4'h1;
    localparam logic [3:0] RESULT_FAIL  = 4'h2;
    localparam logic [3:0] RESULT_NOVEC = 4'h3;
    localparam logic [3:0] RESULT_BUSY  = 4'hB;

    // x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/skullfet_inv_tester_if.sv
// Control/status bundle between the tester and its register wrapper.
interface skullfet_inv_tester_if #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SETTLE_W = 8
);
    logic                start_i;
    logic                abort_i;
    logic [CNT_W-1:0]    num_vectors_i;
    logic [SETTLE_W-1:0] settle_cycles_i;
    logic                busy_o;
    logic                done_o;
    logic [CNT_W-1:0]    pass_cnt_o;
    logic [CNT_W-1:0]    fail_cnt_o;
    logic [CNT_W-1:0]    first_fail_o;
    logic [3:0]          result_o;

    modport slave (
        input  start_i, abort_i, num_vectors_i, settle_cycles_i,
        output busy_o, done_o, pass_cnt_o, fail_cnt_o, first_fail_o, result_o
    );

    modport master (
        output start_i, abort_i, num_vectors_i, settle_cycles_i,
        input  busy_o, done_o, pass_cnt_o, fail_cnt_o, first_fail_o, result_o
    );
endinterface

// File: rtl/skullfet_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous seed load and single-step advance.
module skullfet_lfsr16
    import skullfet_tester_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        step_i,
    input  logic [15:0] seed_i,
    output logic [15:0] state_o
);
    logic [15:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= seed_i;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;
endmodule

// File: rtl/skullfet_inv_tester.sv
// Drives a pseudo-random bit stream into the SkullFET inverter and scores each
// synchronised response against the inverted drive bit.
module skullfet_inv_tester
    import skullfet_tester_pkg::*;
#(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned SETTLE_W  = 8,
    parameter logic [15:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    skullfet_inv_tester_if.slave  ctl_io,
    input  logic                  inv_out_i,
    output logic                  inv_in_o,
    output logic                  inv_oeb_o
);
    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SeedEff = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic [CNT_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    pass_q, pass_d;
    logic [CNT_W-1:0]    fail_q, fail_d;
    logic [CNT_W-1:0]    ff_q, ff_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic [SETTLE_W-1:0] scnt_q, scnt_d;
    logic                novec_q, novec_d;
    logic                inv_in_q, inv_in_d;
    logic                sync1_q, sync2_q;
    logic                lfsr_load, lfsr_step;
    logic [15:0]         lfsr_state;
    logic [SETTLE_W-1:0] settle_eff;
    logic                busy;

    skullfet_lfsr16 u_lfsr (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .load_i  (lfsr_load),
        .step_i  (lfsr_step),
        .seed_i  (SeedEff),
        .state_o (lfsr_state)
    );

    assign settle_eff = (ctl_io.settle_cycles_i < SETTLE_W'(2)) ? SETTLE_W'(2)
                                                                : ctl_io.settle_cycles_i;

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        idx_d     = idx_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
        ff_d      = ff_q;
        settle_d  = settle_q;
        scnt_d    = scnt_q;
        novec_d   = novec_q;
        inv_in_d  = inv_in_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;

        if (ctl_io.abort_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (ctl_io.start_i) begin
                        pass_d    = '0;
                        fail_d    = '0;
                        ff_d      = '1;
                        idx_d     = '0;
                        lfsr_load = 1'b1;
                        if (ctl_io.num_vectors_i == '0) begin
                            novec_d = 1'b1;
                            state_d = StDone;
                        end else begin
                            novec_d  = 1'b0;
                            num_d    = ctl_io.num_vectors_i;
                            settle_d = settle_eff;
                            state_d  = StDrive;
                        end
                    end
                end
                StDrive: begin
                    inv_in_d = lfsr_state[0];
                    scnt_d   = settle_q;
                    state_d  = StSettle;
                end
                StSettle: begin
                    if (scnt_q <= SETTLE_W'(1)) begin
                        state_d = StSample;
                    end else begin
                        scnt_d = scnt_q - SETTLE_W'(1);
                    end
                end
                StSample: begin
                    lfsr_step = 1'b1;
                    // A healthy inverter returns the complement of the drive bit.
                    if (sync2_q != inv_in_q) begin
                        pass_d = pass_q + CNT_W'(1);
                    end else begin
                        if (fail_q != '1) fail_d = fail_q + CNT_W'(1);
                        if (fail_q == '0) ff_d = idx_q;
                    end
                    if (idx_q == num_q - CNT_W'(1)) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = StDrive;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= StIdle;
            num_q    <= '0;
            idx_q    <= '0;
            pass_q   <= '0;
            fail_q   <= '0;
            ff_q     <= '1;
            settle_q <= '0;
            scnt_q   <= '0;
            novec_q  <= 1'b0;
            inv_in_q <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            idx_q    <= idx_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            ff_q     <= ff_d;
            settle_q <= settle_d;
            scnt_q   <= scnt_d;
            novec_q  <= novec_d;
            inv_in_q <= inv_in_d;
            sync1_q  <= inv_out_i;
            sync2_q  <= sync1_q;
        end
    end

    assign busy = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);

    always_comb begin
        unique case (state_q)
            StDrive, StSettle, StSample: ctl_io.result_o = RESULT_BUSY;
            StDone: begin
                if (novec_q)           ctl_io.result_o = RESULT_NOVEC;
                else if (fail_q == '0) ctl_io.result_o = RESULT_PASS;
                else                   ctl_io.result_o = RESULT_FAIL;
            end
            default: ctl_io.result_o = RESULT_IDLE;
        endcase
    end

    assign ctl_io.busy_o       = busy;
    assign ctl_io.done_o       = (state_q == StDone);
    assign ctl_io.pass_cnt_o   = pass_q;
    assign ctl_io.fail_cnt_o   = fail_q;
    assign ctl_io.first_fail_o = ff_q;
    assign inv_in_o            = inv_in_q;
    assign inv_oeb_o           = ~busy;
endmodule

// File: tb/tb_skullfet_inv_tester.sv
// Bench for skullfet_inv_tester: timeline model of a run plus directed scenarios.
module tb_skullfet_inv_tester;
    localparam int unsigned CW   = 16;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic inv_q  = 1'b0;
    logic glitch = 1'b0;
    logic inv_out, inv_in, inv_oeb;
    int   inv_mode = 0;   // 0 ideal (1-cycle delay), 1 buffer, 2 ideal combinational
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   chk_en = 1'b0;
    int   lat;

    // Run model state: phase 0 idle, 1 running, 2 done
    bit          exp_match [0:63];
    int          m_phase = 0, m_t = 0, m_n = 0, m_s = 4, m_pass = 0, m_fail = 0, m_k = 0;
    logic [15:0] m_ff = 16'hFFFF;
    bit          m_novec = 1'b0;
    logic        m_drive = 1'b0;
    logic [15:0] lfsr_tmp;

    always #5 clk = ~clk;

    skullfet_inv_tester_if #(.CNT_W(CW), .SETTLE_W(8)) ctl ();

    skullfet_inv_tester #(.CNT_W(CW), .SETTLE_W(8), .LFSR_SEED(SEED)) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .ctl_io    (ctl),
        .inv_out_i (inv_out),
        .inv_in_o  (inv_in),
        .inv_oeb_o (inv_oeb)
    );

    always @(posedge clk) inv_q <= ((inv_mode == 1) ? inv_in : ~inv_in) ^ glitch;
    assign inv_out = (inv_mode == 2) ? ~inv_in : inv_q;

    function automatic logic [15:0] model_lfsr(input int steps);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < steps; i++) s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
        return s;
    endfunction

    function automatic logic [3:0] model_result();
        if (m_phase == 1) return 4'hB;
        if (m_phase == 0) return 4'h0;
        if (m_novec) return 4'h3;
        return (m_fail == 0) ? 4'h1 : 4'h2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: time since start decides drive edges (t mod (S+2) == 1) and sample edges (== 0).
    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_pass = 0; m_fail = 0; m_ff = 16'hFFFF; m_novec = 0; m_drive = 0;
        end else if (ctl.abort_i) begin
            m_phase = 0;
        end else if (ctl.start_i && m_phase != 1) begin
            m_pass = 0; m_fail = 0; m_ff = 16'hFFFF;
            if (ctl.num_vectors_i == 0) begin
                m_phase = 2; m_novec = 1;
            end else begin
                m_phase = 1; m_novec = 0; m_t = 0;
                m_n = int'(ctl.num_vectors_i);
                m_s = ((ctl.settle_cycles_i < 2) ? 2 : int'(ctl.settle_cycles_i)) + 2;
            end
        end else if (m_phase == 1) begin
            m_t++;
            if (m_t % m_s == 1) begin
                lfsr_tmp = model_lfsr(m_t / m_s);
                m_drive  = lfsr_tmp[0];
            end
            if (m_t % m_s == 0) begin
                m_k = m_t / m_s - 1;
                if (exp_match[m_k]) m_pass++;
                else begin
                    if (m_fail == 0) m_ff = 16'(m_k);
                    m_fail++;
                end
                if (m_k == m_n - 1) m_phase = 2;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("busy",       ctl.busy_o,       m_phase == 1);
            chk("done",       ctl.done_o,       m_phase == 2);
            chk("result",     ctl.result_o,     model_result());
            chk("oeb",        inv_oeb,          m_phase != 1);
            chk("pass_cnt",   ctl.pass_cnt_o,   m_pass);
            chk("fail_cnt",   ctl.fail_cnt_o,   m_fail);
            chk("first_fail", ctl.first_fail_o, m_ff);
            chk("inv_in",     inv_in,           m_drive);
        end
    end

    // lat counts edges after the start edge until done_o is seen.
    task automatic do_run(input int n, input int s, input int mode, input int gidx,
                          input int busy_at, input int abort_at, input int rst_at);
        bit stop;
        stop     = 1'b0;
        inv_mode = mode;
        for (int k = 0; k < 64; k++) exp_match[k] = (mode != 1) && (k != gidx);
        ctl.num_vectors_i   = 16'(n);
        ctl.settle_cycles_i = 8'(s);
        ctl.start_i = 1'b1;
        @(posedge clk); #1;
        ctl.start_i = 1'b0;
        lat = 0;
        while (!stop && ctl.done_o !== 1'b1 && lat < 2000) begin
            ctl.start_i = (lat == busy_at);
            if (lat == gidx * (s + 2)) glitch = 1'b1;
            if (lat == (gidx + 1) * (s + 2)) glitch = 1'b0;
            if (lat == abort_at) ctl.abort_i = 1'b1;
            if (lat == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            if (ctl.abort_i || rst) begin
                ctl.abort_i = 1'b0;
                rst = 1'b0;
                stop = 1'b1;
            end
            ctl.start_i = 1'b0;
            lat++;
        end
        glitch = 1'b0;
        if (!stop) chk("run_done_within_bound", ctl.done_o, 1'b1);
    endtask

    initial begin
        ctl.start_i = 1'b0;
        ctl.abort_i = 1'b0;
        ctl.num_vectors_i = '0;
        ctl.settle_cycles_i = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy",   ctl.busy_o,       0);
        chk("rst_result", ctl.result_o,     0);
        chk("rst_oeb",    inv_oeb,          1);
        chk("rst_ff",     ctl.first_fail_o, 16'hFFFF);
        chk("rst_inv_in", inv_in,           0);
        chk("model_lfsr3", model_lfsr(3),   16'h670F);

        // Ideal inverter, stray start mid-run
        do_run(16, 4, 0, -1, 20, -1, -1);
        chk("t1_lat", lat, 96);
        chk("t1_pass", ctl.pass_cnt_o, 16);
        chk("t1_fail", ctl.fail_cnt_o, 0);
        chk("t1_ff", ctl.first_fail_o, 16'hFFFF);
        chk("t1_result", ctl.result_o, 1);

        // Buffer instead of inverter
        do_run(10, 3, 1, -1, -1, -1, -1);
        chk("t2_lat", lat, 50);
        chk("t2_pass", ctl.pass_cnt_o, 0);
        chk("t2_fail", ctl.fail_cnt_o, 10);
        chk("t2_ff", ctl.first_fail_o, 0);
        chk("t2_result", ctl.result_o, 2);

        // Single glitch on vector 5
        do_run(8, 4, 0, 5, -1, -1, -1);
        chk("t3_lat", lat, 48);
        chk("t3_pass", ctl.pass_cnt_o, 7);
        chk("t3_fail", ctl.fail_cnt_o, 1);
        chk("t3_ff", ctl.first_fail_o, 5);
        chk("t3_result", ctl.result_o, 2);

        // No vectors
        do_run(0, 4, 0, -1, -1, -1, -1);
        chk("t4_lat", lat, 0);
        chk("t4_result", ctl.result_o, 3);
        chk("t4_pass", ctl.pass_cnt_o, 0);
        chk("t4_fail", ctl.fail_cnt_o, 0);

        // Abort and start together from DONE
        ctl.num_vectors_i = 16'd4;
        ctl.abort_i = 1'b1;
        ctl.start_i = 1'b1;
        @(posedge clk); #1;
        ctl.abort_i = 1'b0;
        ctl.start_i = 1'b0;
        chk("t5_result", ctl.result_o, 0);
        chk("t5_busy", ctl.busy_o, 0);
        chk("t5_done", ctl.done_o, 0);

        // Settle of 0 behaves as 2
        do_run(4, 0, 2, -1, -1, -1, -1);
        chk("t6_lat", lat, 16);
        chk("t6_pass", ctl.pass_cnt_o, 4);
        chk("t6_result", ctl.result_o, 1);

        // Abort after three samples, then a full rerun
        do_run(10, 3, 0, -1, -1, 15, -1);
        chk("t7_result", ctl.result_o, 0);
        chk("t7_oeb", inv_oeb, 1);
        chk("t7_pass", ctl.pass_cnt_o, 3);
        chk("t7_busy", ctl.busy_o, 0);
        do_run(10, 3, 0, -1, -1, -1, -1);
        chk("t7b_lat", lat, 50);
        chk("t7b_pass", ctl.pass_cnt_o, 10);
        chk("t7b_result", ctl.result_o, 1);

        // Reset mid-run
        do_run(16, 4, 0, -1, -1, -1, 40);
        chk("t8_pass", ctl.pass_cnt_o, 0);
        chk("t8_ff", ctl.first_fail_o, 16'hFFFF);
        chk("t8_result", ctl.result_o, 0);
        chk("t8_oeb", inv_oeb, 1);
        chk("t8_inv_in", inv_in, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/skullfet_inv_tester.md
Name: skullfet_inv_tester

Overview:
- On-chip stimulus/checker for the SkullFET inverter inside the user project area; it feeds the inverter input pad (mprj_io[8]) and consumes the inverter output pad (mprj_io[9]).
- Drives a pseudo-random bit sequence and samples the response after a programmable settle time.
- Counts passes and failures and reports a 4-bit result code that firmware forwards to the management SoC.
- Control and status go through logic-analyzer/Wishbone-mapped registers in the wrapper.

Parameters:
- CNT_W, 16, width of the vector count and of the pass/fail counters.
- SETTLE_W, 8, width of the settle-cycle counter.
- LFSR_SEED, 16'hACE1, LFSR reset/start value; a value of 0 is replaced by 16'h0001.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  single-cycle pulse; starts a run (from IDLE or DONE).
- abort_i  in  1  returns to IDLE from any state; counters hold.
- num_vectors_i  in  CNT_W  number of vectors per run; sampled on start.
- settle_cycles_i  in  SETTLE_W  wait between drive and sample; sampled on start; values <2 are treated as 2.
- inv_out_i  in  1  inverter response pad; asynchronous.
- inv_in_o  out  1  drive to inverter input pad.
- inv_oeb_o  out  1  pad output-enable-bar; 0 while BUSY, 1 otherwise.
- busy_o  out  1  run in progress.
- done_o  out  1  run finished; held until next start, abort or reset.
- pass_cnt_o  out  CNT_W  vectors matched.
- fail_cnt_o  out  CNT_W  vectors mismatched; saturates at all-ones.
- first_fail_o  out  CNT_W  index of first mismatch; all-ones if none.
- result_o  out  4  0=IDLE, B=BUSY, 1=PASS, 2=FAIL, 3=NOVEC.

Behaviour:
- Clock and reset: one clock (wb_clk_i); synchronous, active-high reset (wb_rst_i).
- Reset values: state IDLE; inv_in_o=0; inv_oeb_o=1; busy_o=0; done_o=0; counters 0; first_fail_o all-ones; result_o=0; LFSR=seed; both synchronizer flops 0.
- Synchronizer: inv_out_i passes through a 2-flop synchronizer; the compare uses the second flop only.
- LFSR: 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1, shift-left, feedback into bit0. Drive bit is lfsr[0]. The LFSR is reloaded with the seed on every start, so every run drives the same sequence.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE/DONE + start_i, num_vectors_i==0:
  - go to DONE next cycle with result 3;
  - counters cleared; first_fail all-ones.
- IDLE/DONE + start_i, num_vectors_i>0:
  - latch num_vectors and settle cycles;
  - clear counters; first_fail all-ones; index=0;
  - busy=1, done=0, result=B; go to DRIVE.
- DRIVE (1 cycle): inv_in_o<=lfsr[0]; load settle counter; go to SETTLE.
- SETTLE: count down; SAMPLE is entered exactly S cycles after the DRIVE cycle (S = effective settle cycles).
- SAMPLE (1 cycle):
  - expected = ~inv_in_o;
  - match: pass_cnt+1;
  - mismatch: fail_cnt+1 (saturating); if it is the first failure, first_fail<=index;
  - advance LFSR one step;
  - if index==num_vectors-1: go to DONE; otherwise index+1 and go to DRIVE.
- DONE: busy=0, done=1; result = 1 if fail_cnt==0, else 2. inv_in_o holds its last value.
- Run latency: exactly N*(S+2) cycles from the cycle after start to the first cycle of done_o=1.
- start_i while BUSY: ignored.
- abort_i: takes priority over start_i in the same cycle; from any state go to IDLE next cycle; busy=0, done=0, result=0, inv_oeb_o=1; counters and first_fail hold.
- Reset mid-run: all state returns to reset values on the next edge.
- pass_cnt never overflows, because N ≤ 2^CNT_W-1.

Decomposition:
- Package skullfet_tester_pkg:
  - FSM state enum;
  - RESULT_* 4-bit constants;
  - LFSR tap mask and default seed.
- One sub-module: skullfet_lfsr16 (load, step, seed input, 16-bit state out). The synchronizer stays inline.

Test Plan:
- Ideal inverter model (inv_out = ~inv_in, 1-cycle delay), N=16, S=4 -> done after 96 cycles; pass=16, fail=0, first_fail=FFFF, result=1.
- inv_out tied to inv_in (buffer), N=10, S=3 -> fail=10, pass=0, first_fail=0, result=2.
- Ideal model with one forced glitch at vector 5, N=8 -> pass=7, fail=1, first_fail=5, result=2.
- Boundary inputs:
  - N=0 start -> DONE in 1 cycle, result=3, counts 0;
  - S=0 -> behaves as S=2 (N=4 completes in 16 cycles).
- abort_i at vector 3 of 10 -> IDLE next cycle, result=0, oeb=1, pass=3 held; a new start then runs a full pass of 10.
- Reset handling:
  - wb_rst_i mid-run -> all outputs at reset values;
  - start_i during BUSY ignored;
  - abort and start in the same cycle -> IDLE.
